remote_key_dispatcher: RTL

- Sits between the IR receiver (`RemoteController`: `Tecla[7:0]`, `Ready`) and the application logic.
- Detects each new key event, optionally suppresses auto-repeats of the same key, and buffers events in a small FIFO.
- Delivers events to one consumer over a valid/ack handshake, so no key is lost while the consumer is busy.

---
 rtl/remote_pkg.sv | 8 +
 rtl/remote_key_dispatcher_if.sv | 18 +
 rtl/remote_key_dispatcher_key_fifo.sv | 49 ++++
 rtl/remote_key_dispatcher.sv | 79 +++++++
 4 files changed

// File: rtl/remote_pkg.sv
// Shared key-path definitions for the IR receiver and the key dispatcher.
package remote_pkg;
  localparam int KEY_W               = 8;
  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_HOLD_CYCLES = 1000;

  typedef enum logic {HELD = 1'b0, ARMED = 1'b1} ingress_state_e;
endpackage

// File: rtl/remote_key_dispatcher_if.sv
// Receiver-to-consumer key bus: ingress (Tecla/Ready) plus valid/ack egress.
interface remote_key_dispatcher_if #(parameter int DEPTH = remote_pkg::DEFAULT_DEPTH);
  import remote_pkg::*;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [KEY_W-1:0] Tecla;
  logic             Ready;
  logic [KEY_W-1:0] Key_Out;
  logic             Key_Valid;
  logic             Key_Ack;
  logic [CNT_W-1:0] Count;
  logic             Overflow;

  modport master (output Tecla, Ready, Key_Ack,
                  input  Key_Out, Key_Valid, Count, Overflow);
  modport slave  (input  Tecla, Ready, Key_Ack,
                  output Key_Out, Key_Valid, Count, Overflow);
endinterface

// File: rtl/remote_key_dispatcher_key_fifo.sv
// Key FIFO with registered storage; full/empty come from the entry count.
module key_fifo
  import remote_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [KEY_W-1:0] wr_data,
  input  logic             pop,
  output logic [KEY_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [DEPTH-1:0][KEY_W-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/remote_key_dispatcher.sv
// One event per Ready rising edge, buffered for a valid/ack consumer.
// Optional repeat suppression is built when REMOTE_REPEAT_FILTER_EN is defined.
module remote_key_dispatcher
  import remote_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input logic                     Clock,
  input logic                     Reset,
  remote_key_dispatcher_if.slave  bus
);
  ingress_state_e state, state_nxt;
  logic           sample, accept, repeat_hit, fifo_full, fifo_empty, drop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= HELD;
    else       state <= state_nxt;
  end

  // HELD on reset means a Ready already high at release is ignored until it drops.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      HELD:    if (!bus.Ready) state_nxt = ARMED;
      ARMED:   if (bus.Ready) begin
        sample    = 1'b1;
        state_nxt = HELD;
      end
      default: state_nxt = HELD;
    endcase
  end

`ifdef REMOTE_REPEAT_FILTER_EN
  localparam int TMR_W = $clog2(HOLD_CYCLES + 1);
  logic [TMR_W-1:0] hold_tmr;
  logic [KEY_W-1:0] last_key;

  // Suppressed repeats still reload the window, so a held-down key stays quiet.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_tmr <= '0;
      last_key <= '0;
    end else if (sample) begin
      hold_tmr <= TMR_W'(HOLD_CYCLES);
      last_key <= bus.Tecla;
    end else if (hold_tmr != '0) begin
      hold_tmr <= hold_tmr - TMR_W'(1);
    end
  end

  assign repeat_hit = (bus.Tecla == last_key) && (hold_tmr != '0);
`else
  assign repeat_hit = 1'b0;
`endif

  assign accept = sample & ~repeat_hit;
  assign drop   = accept & fifo_full & ~(bus.Key_Ack & ~fifo_empty);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     bus.Overflow <= 1'b0;
    else if (drop) bus.Overflow <= 1'b1;
  end

  key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push    (accept),
    .wr_data (bus.Tecla),
    .pop     (bus.Key_Ack),
    .rd_data (bus.Key_Out),
    .count   (bus.Count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.Key_Valid = ~fifo_empty;
endmodule
